rob_buffer: RTL and testbench

- In-order reorder buffer at the far end of the CDB and of the operand-lookup port used by the reservation stations.
- The dispatcher allocates entries. Both CDB ports write results into entries.
- Reservation stations query an entry by ROB number through index/ready/value.
- The head entry retires to the register file in program order, one entry per cycle.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/rob_lookup.sv | 56 +++++
 rtl/rob_buffer.sv | 132 +++++++++++++
 tb/tb_rob_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the reorder-buffer entry type
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int ROB_NUM_W = 6;
    localparam int REG_W     = 5;

    // Any ROB number >= 16 means "no producer"; this is the canonical one.
    localparam logic [ROB_NUM_W-1:0] INVALID_NUM = 6'b010000;

    typedef struct packed {
        logic             valid;
        logic             rdy;
        logic [REG_W-1:0] dest;
        logic [XLEN-1:0]  data;
    } rob_entry_t;

endpackage

// File: rtl/rob_lookup.sv
// rtl/rob_lookup.sv - operand lookup mux by ROB number (ROB_CDB_BYPASS_EN adds same-cycle CDB bypass)
module rob_lookup
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic [ROB_NUM_W-1:0] i_index,
    input  logic [DEPTH-1:0]     i_valid,
    input  logic [DEPTH-1:0]     i_rdy,
    input  logic [XLEN-1:0]      i_data [DEPTH],
    input  logic                 i_cdb1_en,
    input  logic [ROB_NUM_W-1:0] i_cdb1_num,
    input  logic [XLEN-1:0]      i_cdb1_data,
    input  logic                 i_cdb2_en,
    input  logic [ROB_NUM_W-1:0] i_cdb2_num,
    input  logic [XLEN-1:0]      i_cdb2_data,
    output logic                 o_ready,
    output logic [XLEN-1:0]      o_value
);

    localparam int PW = $clog2(DEPTH);

    logic          w_in_range;
    logic [PW-1:0] w_idx;

    assign w_in_range = (i_index < ROB_NUM_W'(DEPTH));
    assign w_idx      = i_index[PW-1:0];

    // Only a live entry can answer; a bypass hit (port 2 first) beats stored data.
    always_comb begin
        o_ready = 1'b0;
        o_value = '0;
        if (w_in_range && i_valid[w_idx]) begin
`ifdef ROB_CDB_BYPASS_EN
            if (i_cdb2_en && (i_cdb2_num == i_index)) begin
                o_ready = 1'b1;
                o_value = i_cdb2_data;
            end else if (i_cdb1_en && (i_cdb1_num == i_index)) begin
                o_ready = 1'b1;
                o_value = i_cdb1_data;
            end else
`endif
            if (i_rdy[w_idx]) begin
                o_ready = 1'b1;
                o_value = i_data[w_idx];
            end
        end
    end

`ifndef ROB_CDB_BYPASS_EN
    logic w_unused_cdb;
    assign w_unused_cdb = ^{i_cdb1_en, i_cdb1_num, i_cdb1_data,
                            i_cdb2_en, i_cdb2_num, i_cdb2_data};
`endif

endmodule

// File: rtl/rob_buffer.sv
// rtl/rob_buffer.sv - in-order reorder buffer: alloc, dual CDB write, lookup, in-order commit (lookup bypass via ROB_CDB_BYPASS_EN)
module rob_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 alloc_en,
    input  logic [REG_W-1:0]     alloc_dest,
    output logic [ROB_NUM_W-1:0] alloc_rob_num,
    output logic                 full,
    input  logic                 CDBiscast,
    input  logic [ROB_NUM_W-1:0] CDBrobNum,
    input  logic [XLEN-1:0]      CDBdata,
    input  logic                 CDBiscast2,
    input  logic [ROB_NUM_W-1:0] CDBrobNum2,
    input  logic [XLEN-1:0]      CDBdata2,
    input  logic [ROB_NUM_W-1:0] index,
    output logic                 ready,
    output logic [XLEN-1:0]      value,
    output logic                 commit_valid,
    output logic [REG_W-1:0]     commit_dest,
    output logic [XLEN-1:0]      commit_data,
    output logic [ROB_NUM_W-1:0] commit_rob_num,
    output logic                 commit_we
);

    localparam int PW = $clog2(DEPTH);

    rob_entry_t    r_entries [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;

    logic          w_alloc;
    logic          w_commit;
    logic          w_cdb1_hit;
    logic          w_cdb2_hit;
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_rdy;
    logic [XLEN-1:0]  w_data [DEPTH];

    // full comes from the start-of-cycle count, so a same-cycle commit never frees a slot early
    assign full          = (r_count == (PW+1)'(DEPTH));
    assign alloc_rob_num = ROB_NUM_W'(r_tail);
    assign w_alloc       = alloc_en && !full;
    assign w_commit      = r_entries[r_head].valid && r_entries[r_head].rdy;
    assign w_cdb1_hit    = CDBiscast  && (CDBrobNum  < ROB_NUM_W'(DEPTH))
                           && r_entries[CDBrobNum[PW-1:0]].valid;
    assign w_cdb2_hit    = CDBiscast2 && (CDBrobNum2 < ROB_NUM_W'(DEPTH))
                           && r_entries[CDBrobNum2[PW-1:0]].valid;
    assign commit_we     = commit_valid && (commit_dest != '0);

    // Flatten entry state for the lookup mux
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid[i] = r_entries[i].valid;
            w_rdy[i]   = r_entries[i].rdy;
            w_data[i]  = r_entries[i].data;
        end
    end

    // Entry, pointer and commit state; flush overrides everything else in its cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_entries[i] <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            commit_valid   <= 1'b0;
            commit_dest    <= '0;
            commit_data    <= '0;
            commit_rob_num <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
                r_entries[i].rdy   <= 1'b0;
            end
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            commit_valid <= 1'b0;
        end else begin
            // Port 2 is written last so it wins a same-entry collision
            if (w_cdb1_hit) begin
                r_entries[CDBrobNum[PW-1:0]].rdy  <= 1'b1;
                r_entries[CDBrobNum[PW-1:0]].data <= CDBdata;
            end
            if (w_cdb2_hit) begin
                r_entries[CDBrobNum2[PW-1:0]].rdy  <= 1'b1;
                r_entries[CDBrobNum2[PW-1:0]].data <= CDBdata2;
            end
            if (w_alloc) begin
                r_entries[r_tail] <= '{valid: 1'b1, rdy: 1'b0, dest: alloc_dest, data: '0};
                r_tail            <= r_tail + PW'(1);
            end
            commit_valid <= w_commit;
            if (w_commit) begin
                r_entries[r_head].valid <= 1'b0;
                commit_dest    <= r_entries[r_head].dest;
                commit_data    <= r_entries[r_head].data;
                commit_rob_num <= ROB_NUM_W'(r_head);
                r_head         <= r_head + PW'(1);
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    rob_lookup #(
        .DEPTH (DEPTH)
    ) u_lookup (
        .i_index     (index),
        .i_valid     (w_valid),
        .i_rdy       (w_rdy),
        .i_data      (w_data),
        .i_cdb1_en   (CDBiscast),
        .i_cdb1_num  (CDBrobNum),
        .i_cdb1_data (CDBdata),
        .i_cdb2_en   (CDBiscast2),
        .i_cdb2_num  (CDBrobNum2),
        .i_cdb2_data (CDBdata2),
        .o_ready     (ready),
        .o_value     (value)
    );

endmodule

// File: tb/tb_rob_buffer.sv
// tb/tb_rob_buffer.sv - directed self-checking bench for rob_buffer
module tb_rob_buffer;
    import cpu_pkg::*;

    logic                 clock;
    logic                 reset;
    logic                 flush;
    logic                 alloc_en;
    logic [REG_W-1:0]     alloc_dest;
    logic [ROB_NUM_W-1:0] alloc_rob_num;
    logic                 full;
    logic                 CDBiscast;
    logic [ROB_NUM_W-1:0] CDBrobNum;
    logic [XLEN-1:0]      CDBdata;
    logic                 CDBiscast2;
    logic [ROB_NUM_W-1:0] CDBrobNum2;
    logic [XLEN-1:0]      CDBdata2;
    logic [ROB_NUM_W-1:0] index;
    logic                 ready;
    logic [XLEN-1:0]      value;
    logic                 commit_valid;
    logic [REG_W-1:0]     commit_dest;
    logic [XLEN-1:0]      commit_data;
    logic [ROB_NUM_W-1:0] commit_rob_num;
    logic                 commit_we;

    int total = 0;
    int bad   = 0;

    rob_buffer #(.DEPTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .alloc_en       (alloc_en),
        .alloc_dest     (alloc_dest),
        .alloc_rob_num  (alloc_rob_num),
        .full           (full),
        .CDBiscast      (CDBiscast),
        .CDBrobNum      (CDBrobNum),
        .CDBdata        (CDBdata),
        .CDBiscast2     (CDBiscast2),
        .CDBrobNum2     (CDBrobNum2),
        .CDBdata2       (CDBdata2),
        .index          (index),
        .ready          (ready),
        .value          (value),
        .commit_valid   (commit_valid),
        .commit_dest    (commit_dest),
        .commit_data    (commit_data),
        .commit_rob_num (commit_rob_num),
        .commit_we      (commit_we)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; alloc_en = 1'b0; alloc_dest = '0;
        CDBiscast = 1'b0; CDBrobNum = '0; CDBdata = '0;
        CDBiscast2 = 1'b0; CDBrobNum2 = '0; CDBdata2 = '0; index = '0;
        tick(); tick();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_commit_valid got=%0h exp=0", commit_valid); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h exp=0", full); end
        total++; if (alloc_rob_num !== 6'd0) begin bad++; $display("FAIL reset_alloc_rob_num got=%0h exp=0", alloc_rob_num); end
        total++; if (commit_data !== 32'h0) begin bad++; $display("FAIL reset_commit_data got=%0h exp=0", commit_data); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", ready); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alloc();
        alloc_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alloc_dest = 5'(5 + i);
            #1;
            total++; if (alloc_rob_num !== 6'(i)) begin bad++; $display("FAIL alloc_rob_num_%0d got=%0h exp=%0h", i, alloc_rob_num, i); end
            tick();
        end
        alloc_en = 1'b0;
        #1;
        total++; if (alloc_rob_num !== 6'd3) begin bad++; $display("FAIL alloc_after3 got=%0h exp=3", alloc_rob_num); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL alloc_full got=%0h exp=0", full); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL alloc_no_commit got=%0h exp=0", commit_valid); end
    endtask

    task automatic test_cdb_order();
        logic exp_bypass;
`ifdef ROB_CDB_BYPASS_EN
        exp_bypass = 1'b1;
`else
        exp_bypass = 1'b0;
`endif
        CDBiscast = 1'b1; CDBrobNum = 6'd1; CDBdata = 32'h11; index = 6'd1;
        #1;
        total++; if (ready !== exp_bypass) begin bad++; $display("FAIL same_cycle_ready got=%0h exp=%0h", ready, exp_bypass); end
        tick();
        CDBiscast = 1'b0;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL lookup1_ready got=%0h exp=1", ready); end
        total++; if (value !== 32'h11) begin bad++; $display("FAIL lookup1_value got=%0h exp=11", value); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL head_not_ready_commit got=%0h exp=0", commit_valid); end
        CDBiscast2 = 1'b1; CDBrobNum2 = 6'd0; CDBdata2 = 32'h22;
        tick();
        CDBiscast2 = 1'b0;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL commit_latency got=%0h exp=0", commit_valid); end
        tick();
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL c0_valid got=%0h exp=1", commit_valid); end
        total++; if (commit_rob_num !== 6'd0) begin bad++; $display("FAIL c0_rob got=%0h exp=0", commit_rob_num); end
        total++; if (commit_dest !== 5'd5) begin bad++; $display("FAIL c0_dest got=%0h exp=5", commit_dest); end
        total++; if (commit_data !== 32'h22) begin bad++; $display("FAIL c0_data got=%0h exp=22", commit_data); end
        total++; if (commit_we !== 1'b1) begin bad++; $display("FAIL c0_we got=%0h exp=1", commit_we); end
        tick();
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL c1_valid got=%0h exp=1", commit_valid); end
        total++; if (commit_rob_num !== 6'd1) begin bad++; $display("FAIL c1_rob got=%0h exp=1", commit_rob_num); end
        total++; if (commit_dest !== 5'd6) begin bad++; $display("FAIL c1_dest got=%0h exp=6", commit_dest); end
        total++; if (commit_data !== 32'h11) begin bad++; $display("FAIL c1_data got=%0h exp=11", commit_data); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL retired_lookup_ready got=%0h exp=0", ready); end
        tick();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL c2_valid got=%0h exp=0", commit_valid); end
        total++; if (commit_dest !== 5'd6) begin bad++; $display("FAIL c2_dest_hold got=%0h exp=6", commit_dest); end
    endtask

    task automatic test_collision();
        alloc_en = 1'b1; alloc_dest = 5'd8;
        tick(); tick();
        alloc_en = 1'b0;
        CDBiscast = 1'b1;  CDBrobNum = 6'd3;  CDBdata = 32'hA;
        CDBiscast2 = 1'b1; CDBrobNum2 = 6'd3; CDBdata2 = 32'hB;
        tick();
        CDBiscast = 1'b0; CDBiscast2 = 1'b0; index = 6'd3;
        #1;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL coll_ready got=%0h exp=1", ready); end
        total++; if (value !== 32'hB) begin bad++; $display("FAIL coll_value got=%0h exp=b", value); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL coll_commit got=%0h exp=0", commit_valid); end
        CDBiscast = 1'b1;  CDBrobNum = 6'd9;   CDBdata = 32'h99;
        CDBiscast2 = 1'b1; CDBrobNum2 = 6'd20; CDBdata2 = 32'h77;
        tick();
        CDBiscast = 1'b0; CDBiscast2 = 1'b0; index = 6'd9;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL unalloc9_ready got=%0h exp=0", ready); end
        total++; if (value !== 32'h0) begin bad++; $display("FAIL unalloc9_value got=%0h exp=0", value); end
        index = 6'd20;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL oor20_ready got=%0h exp=0", ready); end
        index = 6'd3;
        #1;
        total++; if (value !== 32'hB) begin bad++; $display("FAIL entry3_kept got=%0h exp=b", value); end
        total++; if (alloc_rob_num !== 6'd5) begin bad++; $display("FAIL drop_alloc_num got=%0h exp=5", alloc_rob_num); end
    endtask

    task automatic test_full();
        reset = 1'b1; #1; reset = 1'b0;
        alloc_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alloc_dest = 5'(i);
            tick();
            if (i == 14) begin total++; if (full !== 1'b0) begin bad++; $display("FAIL full_at15 got=%0h exp=0", full); end end
            if (i == 15) begin total++; if (full !== 1'b1) begin bad++; $display("FAIL full_at16 got=%0h exp=1", full); end end
        end
        alloc_dest = 5'd9;
        tick();
        total++; if (alloc_rob_num !== 6'd0) begin bad++; $display("FAIL alloc17_ignored got=%0h exp=0", alloc_rob_num); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL alloc17_full got=%0h exp=1", full); end
        CDBiscast = 1'b1; CDBrobNum = 6'd0; CDBdata = 32'h44;
        tick();
        CDBiscast = 1'b0;
        total++; if (full !== 1'b1) begin bad++; $display("FAIL cdb_edge_full got=%0h exp=1", full); end
        tick();
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL x0_commit_valid got=%0h exp=1", commit_valid); end
        total++; if (commit_dest !== 5'd0) begin bad++; $display("FAIL x0_commit_dest got=%0h exp=0", commit_dest); end
        total++; if (commit_data !== 32'h44) begin bad++; $display("FAIL x0_commit_data got=%0h exp=44", commit_data); end
        total++; if (commit_we !== 1'b0) begin bad++; $display("FAIL x0_commit_we got=%0h exp=0", commit_we); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL blocked_alloc_full got=%0h exp=0", full); end
        total++; if (alloc_rob_num !== 6'd0) begin bad++; $display("FAIL blocked_alloc_num got=%0h exp=0", alloc_rob_num); end
        tick();
        alloc_en = 1'b0;
        total++; if (alloc_rob_num !== 6'd1) begin bad++; $display("FAIL wrap_alloc_num got=%0h exp=1", alloc_rob_num); end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%0h exp=1", full); end
    endtask

    task automatic test_flush();
        reset = 1'b1; #1; reset = 1'b0;
        alloc_en = 1'b1; alloc_dest = 5'd3;
        repeat (5) tick();
        alloc_en = 1'b0;
        CDBiscast = 1'b1; CDBrobNum = 6'd0; CDBdata = 32'h55;
        tick();
        flush = 1'b1; alloc_en = 1'b1; CDBrobNum = 6'd1; CDBdata = 32'h56;
        tick();
        flush = 1'b0; alloc_en = 1'b0; CDBiscast = 1'b0; index = 6'd0;
        #1;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL flush_commit got=%0h exp=0", commit_valid); end
        total++; if (alloc_rob_num !== 6'd0) begin bad++; $display("FAIL flush_alloc_num got=%0h exp=0", alloc_rob_num); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_lookup0 got=%0h exp=0", ready); end
        index = 6'd1;
        #1;
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_lookup1 got=%0h exp=0", ready); end
        tick();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL flush_commit_next got=%0h exp=0", commit_valid); end
        alloc_en = 1'b1; alloc_dest = 5'd7;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i == 14) begin total++; if (full !== 1'b0) begin bad++; $display("FAIL flush_count15 got=%0h exp=0", full); end end
            if (i == 15) begin total++; if (full !== 1'b1) begin bad++; $display("FAIL flush_count16 got=%0h exp=1", full); end end
        end
        alloc_en = 1'b0;
    endtask

    task automatic test_reset_mid_commit();
        CDBiscast = 1'b1; CDBrobNum = 6'd0; CDBdata = 32'h66;
        tick();
        CDBiscast = 1'b0;
        tick();
        total++; if (commit_data !== 32'h66) begin bad++; $display("FAIL pre_reset_commit_data got=%0h exp=66", commit_data); end
        reset = 1'b1;
        #1;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%0h exp=0", commit_valid); end
        total++; if (commit_data !== 32'h0) begin bad++; $display("FAIL async_reset_data got=%0h exp=0", commit_data); end
        total++; if (commit_dest !== 5'd0) begin bad++; $display("FAIL async_reset_dest got=%0h exp=0", commit_dest); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL async_reset_full got=%0h exp=0", full); end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_cdb_order();
        test_collision();
        test_full();
        test_flush();
        test_reset_mid_commit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
